// File: rtl/dcf_frame_if.sv
// dcf_frame_if: signal bundle between the DCF77 frame controller and its surroundings.
// Date outputs exist only when DCF_DATE_DECODE_EN is defined.
interface dcf_frame_if;
    logic       sgn_in;
    logic       flag_in;
    logic       onoff_sincro;
    logic [6:0] minutes_out;
    logic [5:0] hours_out;
    logic       frame_valid;
    logic       locked;
    logic       bit_err;
`ifdef DCF_DATE_DECODE_EN
    logic [5:0] day_out;
    logic [2:0] wday_out;
    logic [4:0] month_out;
    logic [7:0] year_out;

    modport master (
        input  sgn_in, flag_in,
        output onoff_sincro, minutes_out, hours_out, frame_valid, locked, bit_err,
        output day_out, wday_out, month_out, year_out
    );
    modport slave (
        output sgn_in, flag_in,
        input  onoff_sincro, minutes_out, hours_out, frame_valid, locked, bit_err,
        input  day_out, wday_out, month_out, year_out
    );
`else
    modport master (
        input  sgn_in, flag_in,
        output onoff_sincro, minutes_out, hours_out, frame_valid, locked, bit_err
    );
    modport slave (
        output sgn_in, flag_in,
        input  onoff_sincro, minutes_out, hours_out, frame_valid, locked, bit_err
    );
`endif
endinterface

// File: rtl/dcf_frame_ctrl.sv
// dcf_frame_ctrl: sequences the DCF77 minute-sync detector and decodes 59-bit frames to BCD time.
// Define DCF_DATE_DECODE_EN to add date outputs and the date parity check.
module dcf_frame_ctrl #(
    parameter int CNT_W      = 17,
    parameter int PULSE_MIN  = 40,
    parameter int BIT_THRESH = 150,
    parameter int PULSE_MAX  = 300,
    parameter int PERIOD_MAX = 2100
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    dcf_frame_if.master bus
);
    localparam logic [5:0]       C_LAST_BIT   = 6'd59;
    localparam logic [CNT_W-1:0] C_PULSE_MIN  = CNT_W'(PULSE_MIN);
    localparam logic [CNT_W-1:0] C_BIT_THRESH = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] C_PULSE_MAX  = CNT_W'(PULSE_MAX);
    localparam logic [CNT_W-1:0] C_PERIOD_MAX = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0] C_END_GAP    = CNT_W'(1000);

    typedef enum logic [2:0] {
        S_IDLE, S_HUNT, S_ARM, S_LOW, S_GAP, S_CHECK, S_ERR
    } state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_low_cnt, r_gap_cnt;
    logic [5:0]       r_bit_idx;
    logic [58:0]      r_frame;
    logic             r_sgn_prev;
    logic             r_onoff, r_frame_valid, r_locked, r_bit_err;
    logic [6:0]       r_minutes;
    logic [5:0]       r_hours;

    logic       w_fall, w_bit, w_start, w_to_low, w_take_bit, w_publish;
    logic [3:0] w_min_units, w_hr_units;
    logic [2:0] w_min_tens;
    logic [1:0] w_hr_tens;
    logic       w_marks_ok, w_par_ok, w_bcd_ok, w_date_ok, w_frame_ok;

    assign w_fall = r_sgn_prev & ~bus.sgn_in;
    assign w_bit  = (r_low_cnt >= C_BIT_THRESH);

    assign w_min_units = r_frame[24:21];
    assign w_min_tens  = r_frame[27:25];
    assign w_hr_units  = r_frame[32:29];
    assign w_hr_tens   = r_frame[34:33];

    assign w_marks_ok = ~r_frame[0] & r_frame[20];
    assign w_par_ok   = ~(^r_frame[28:21]) & ~(^r_frame[35:29]);
    assign w_bcd_ok   = (w_min_units <= 4'd9) && (w_min_tens <= 3'd5) && (w_hr_units <= 4'd9) &&
                        ((w_hr_tens < 2'd2) || ((w_hr_tens == 2'd2) && (w_hr_units <= 4'd3)));
`ifdef DCF_DATE_DECODE_EN
    assign w_date_ok  = ~(^r_frame[58:36]);
`else
    assign w_date_ok  = 1'b1;
`endif
    assign w_frame_ok = w_marks_ok & w_par_ok & w_bcd_ok & w_date_ok;
    assign w_publish  = (r_state == S_CHECK) && w_frame_ok;

    // A glitch with bit_idx==0 can only have interrupted ARM, so that is where it returns.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_to_low   = 1'b0;
        w_take_bit = 1'b0;
        unique case (r_state)
            S_IDLE:  w_next = S_HUNT;
            S_HUNT:  if (bus.flag_in) w_next = S_ARM;
            S_ARM: begin
                if (w_fall) begin
                    w_start = 1'b1;
                    w_next  = S_LOW;
                end
            end
            S_LOW: begin
                if (r_low_cnt > C_PULSE_MAX) begin
                    w_next = S_ERR;
                end else if (bus.sgn_in) begin
                    if (r_low_cnt < C_PULSE_MIN) begin
                        w_next = (r_bit_idx == 6'd0) ? S_ARM : S_GAP;
                    end else begin
                        w_take_bit = 1'b1;
                        w_next     = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_bit_idx == C_LAST_BIT) begin
                    if (r_gap_cnt >= C_END_GAP) w_next = S_CHECK;
                    else if (w_fall)            w_next = S_ERR;
                end else if (r_gap_cnt > C_PERIOD_MAX) begin
                    w_next = S_ERR;
                end else if (w_fall) begin
                    w_to_low = 1'b1;
                    w_next   = S_LOW;
                end
            end
            S_CHECK: w_next = w_frame_ok ? S_ARM : S_ERR;
            S_ERR:   w_next = S_HUNT;
            default: w_next = S_IDLE;
        endcase
    end

    // Bits enter at the top so that after 59 shifts frame bit k sits at index k.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= S_IDLE;
            r_sgn_prev <= 1'b1;
            r_low_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_bit_idx  <= '0;
            r_frame    <= '0;
        end else begin
            r_state    <= w_next;
            r_sgn_prev <= bus.sgn_in;

            if (w_start || w_to_low)
                r_low_cnt <= '0;
            else if ((r_state == S_LOW) && !bus.sgn_in)
                r_low_cnt <= r_low_cnt + 1'b1;

            if (w_start || w_take_bit)
                r_gap_cnt <= '0;
            else if ((r_state == S_GAP) && bus.sgn_in)
                r_gap_cnt <= r_gap_cnt + 1'b1;

            if (w_start || (r_state == S_ERR))
                r_bit_idx <= '0;
            else if (w_take_bit)
                r_bit_idx <= r_bit_idx + 1'b1;

            if (r_state == S_ERR)
                r_frame <= '0;
            else if (w_take_bit)
                r_frame <= {w_bit, r_frame[58:1]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_onoff       <= 1'b0;
            r_frame_valid <= 1'b0;
            r_bit_err     <= 1'b0;
            r_locked      <= 1'b0;
            r_minutes     <= '0;
            r_hours       <= '0;
        end else begin
            r_onoff       <= (w_next == S_HUNT) || (w_next == S_ARM);
            r_frame_valid <= w_publish;
            r_bit_err     <= (r_state == S_ERR);
            if (w_publish) begin
                r_locked  <= 1'b1;
                r_minutes <= r_frame[27:21];
                r_hours   <= r_frame[34:29];
            end else if (r_state == S_ERR) begin
                r_locked  <= 1'b0;
            end
        end
    end

    assign bus.onoff_sincro = r_onoff;
    assign bus.minutes_out  = r_minutes;
    assign bus.hours_out    = r_hours;
    assign bus.frame_valid  = r_frame_valid;
    assign bus.locked       = r_locked;
    assign bus.bit_err      = r_bit_err;

`ifdef DCF_DATE_DECODE_EN
    logic [5:0] r_day;
    logic [2:0] r_wday;
    logic [4:0] r_month;
    logic [7:0] r_year;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_day   <= '0;
            r_wday  <= '0;
            r_month <= '0;
            r_year  <= '0;
        end else if (w_publish) begin
            r_day   <= r_frame[41:36];
            r_wday  <= r_frame[44:42];
            r_month <= r_frame[49:45];
            r_year  <= r_frame[57:50];
        end
    end

    assign bus.day_out   = r_day;
    assign bus.wday_out  = r_wday;
    assign bus.month_out = r_month;
    assign bus.year_out  = r_year;
`endif
endmodule

// File: doc/dcf_frame_ctrl.md
Name: dcf_frame_ctrl

Overview:
- Sequences the DCF77 minute-sync detector and decodes each 59-bit DCF77 frame into BCD time.
- Drives the detector's enable (onoff_sincro) and watches its minute-gap flag (flag_in).
- Times each carrier-reduction pulse on sgn_in to classify it as bit 0 or bit 1.
- Shifts bits into a frame register, checks frame parity, and publishes validated minutes and hours to the clock/display logic.

Parameters:
- CNT_W, 17, width of the pulse/gap timing counter.
- PULSE_MIN, 40, minimum low time in cycles for a legal pulse; shorter low periods are glitches and are ignored.
- BIT_THRESH, 150, low time at or above this value decodes as 1; below it decodes as 0.
- PULSE_MAX, 300, low time above this value is a bit error.
- PERIOD_MAX, 2100, maximum high time in cycles between pulses before the frame is aborted.

Ports:
- clk_in  in  1  system clock, 1 kHz tick domain, same clock as the sync detector.
- rst_n_in  in  1  reset, asynchronous, active-low.
- sgn_in  in  1  demodulated DCF77 signal; 1 = full carrier, 0 = carrier reduction (pulse).
- flag_in  in  1  minute-gap flag from the sync detector.
- onoff_sincro  out  1  enable to the sync detector.
- minutes_out  out  7  BCD minutes (frame bits 21-27).
- hours_out  out  6  BCD hours (frame bits 29-34).
- frame_valid  out  1  one-cycle strobe when a new time is published.
- locked  out  1  high after the first valid frame; cleared on any error.
- bit_err  out  1  one-cycle strobe on a timing or parity error.

Behaviour:
- Reset (async, rst_n_in=0):
  - state=IDLE; all counters and the 59-bit frame register cleared.
  - onoff_sincro=0, minutes_out=0, hours_out=0, frame_valid=0, locked=0, bit_err=0.
- State machine, all transitions on posedge clk_in:
  - IDLE: one cycle, then HUNT.
  - HUNT: onoff_sincro=1; wait for flag_in=1, then ARM.
  - ARM: onoff_sincro=1; wait for sgn_in falling edge (registered previous value 1, current 0); this edge is bit 0 start. Set bit_idx=0, cnt=0; go to LOW.
  - LOW: onoff_sincro=0; cnt increments each cycle while sgn_in=0.
    - On sgn_in=1 with cnt<PULSE_MIN: return to the GAP state the pulse interrupted, keeping the GAP count (glitch).
    - On sgn_in=1 with PULSE_MIN<=cnt<=PULSE_MAX: shift bit (cnt>=BIT_THRESH) into frame[bit_idx], bit_idx++, cnt=0, go to GAP.
    - On cnt>PULSE_MAX: go to ERR.
  - GAP: cnt increments while sgn_in=1.
    - Falling edge with bit_idx<59: cnt=0, go to LOW.
    - bit_idx==59: go to CHECK once cnt reaches 1000. No falling edge is allowed before then; a falling edge before cnt reaches 1000 means too many bits and goes to ERR.
    - cnt>PERIOD_MAX with bit_idx<59: go to ERR (lost signal).
  - CHECK: one cycle; evaluate:
    - frame[0]==0 and frame[20]==1;
    - even parity over bits 21-28 and over bits 29-35;
    - minutes BCD digits <=5/9; hours <=23.
    - Pass: latch minutes_out/hours_out, frame_valid=1, locked=1, go to ARM. The current gap is the next minute mark, so ARM waits for the falling edge without re-hunting.
    - Fail: go to ERR.
  - ERR: bit_err=1 for one cycle, locked=0, frame cleared, go to HUNT. Published time is held, not cleared.
- Only one bit is recorded per LOW exit. A falling edge and a timeout in the same cycle resolve in favour of the timeout.
- Outputs are registered; latency is exactly 1 cycle from the CHECK decision to frame_valid.
- The edge detector register resets to 1, so a low sgn_in at reset release does not count as an edge.

Optional Feature:
- DCF_DATE_DECODE_EN defined:
  - Adds outputs day_out[5:0] (bits 36-41), wday_out[2:0] (bits 42-44), month_out[4:0] (bits 45-49), year_out[7:0] (bits 50-57).
  - Adds the even-parity check over bits 36-58 to CHECK.
  - New outputs reset to 0 and latch together with the time.
- DCF_DATE_DECODE_EN undefined: those ports and the date parity check are absent, and bits 36-58 are stored but ignored.

Test Plan:
- Reset, then flag_in pulse, then a valid frame encoding 14:37 with correct parities -> frame_valid one cycle after CHECK; minutes_out=7'h37, hours_out=6'h14; locked=1.
- Two consecutive valid frames (14:37 then 14:38) -> the second frame_valid arrives about 60000 cycles after the first without returning to HUNT; minutes_out=7'h38.
- Frame with bit 28 parity flipped -> bit_err=1 for one cycle, locked=0, outputs hold the previous time, state=HUNT, onoff_sincro=1.
- 20-cycle low glitch inside a gap -> ignored; bit count is unchanged and the frame still decodes correctly.
- sgn_in held high for 2200 cycles mid-frame (bit_idx=30) -> bit_err strobe, then HUNT.
- Assert rst_n_in low mid-frame, asynchronously between clock edges -> all outputs 0 immediately, and onoff_sincro=0 until IDLE→HUNT.
